idex_pipe_reg: RTL
==================

# idex_pipe_reg

ID/EX pipeline register for the 5-stage MIPS core: captures decoded control, operand data and register indices at the end of ID and presents them to EX. It is the consumer of the hazard detection stall. A load-use stall or a branch flush replaces the incoming instruction with a bubble, and a hold freezes the stage. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- DATA_W, 32, operand/immediate/PC width
- REG_AW, 5, register index width
- CTRL_W, 8, packed control word width; layout is {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[1:0]}, MSB first
- CNT_W, 16, event counter width
- Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous active-high reset
- stall_i  in  1  load-use stall from hazard detection; 1 means insert a bubble this cycle
- flush_i  in  1  branch/jump taken; squashes the ID instruction
- hold_i  in  1  freeze the whole stage (downstream multi-cycle stall)
- clr_cnt_i  in  1  synchronous clear of both counters
- valid_i  in  1  ID holds a real instruction
- ctrl_i  in  CTRL_W  decoded control word
- pc4_i, rs_data_i, rt_data_i, imm_i  in  DATA_W each  PC+4, register file reads, sign-extended immediate
- rs_addr_i, rt_addr_i, rd_addr_i  in  REG_AW each  register indices
- valid_o, ctrl_o, pc4_o, rs_data_o, rt_data_o, imm_o, rs_addr_o, rt_addr_o, rd_addr_o  out  same widths  registered copies
- memread_o  out  1  equals ctrl_o[5]; feeds the hazard unit's MemRead input
- stall_cnt_o, flush_cnt_o  out  CNT_W each  saturating event counts

## Operation
- Each rising edge selects exactly one action. Priority is rst_i > flush_i > hold_i > stall_i > load.
  - Reset: every output register becomes 0, including both counters.
  - Flush (bubble): valid_o←0 and ctrl_o←0. Data and index fields hold their previous values. flush_cnt increments.
  - Hold: every pipeline field keeps its value. No counter increments from stall_i.
  - Stall (bubble): same register effect as flush. stall_cnt increments.
  - Load: every field takes its input. valid_o←valid_i. If valid_i=0, ctrl_o←0 regardless of ctrl_i.
- Counters:
  - Each counter increments by 1 on its event and saturates at 2^CNT_W−1 (no wrap).
  - clr_cnt_i forces both counters to 0 and takes precedence over an increment in the same cycle.
  - rst_i takes precedence over clr_cnt_i.
  - flush_i with stall_i in the same cycle increments flush_cnt only.
  - flush_i with hold_i increments flush_cnt; the flush wins.
- The bubble guarantee is that no bubble can write a register or memory: RegWrite, MemWrite and MemRead are all 0 whenever valid_o=0.
- memread_o is purely combinational from ctrl_o, so it is registered state, not an input path.

## Timing
- Latency is 1 cycle from input to output. There are no combinational paths from inputs to outputs.
- Asserting stall_i in cycle N:
  - EX sees a bubble in cycle N+1.
  - The stalled instruction is re-presented by the held IF/ID stage and loads in the first cycle with stall_i=0.
- Reset mid-operation clears the stage on the next edge. Counters restart from 0.
- hold_i held for K cycles freezes the outputs for K cycles. Outputs resume on the first edge with hold_i=0.
- Counter at saturation plus an event keeps its value; there is no overflow flag.

## Structure
- Shared package pipe_pkg holds:
  - the CTRL_W localparam;
  - control bit positions (CTRL_REGWRITE=7, CTRL_MEMTOREG=6, CTRL_MEMREAD=5, CTRL_MEMWRITE=4, CTRL_ALUSRC=3, CTRL_REGDST=2, CTRL_ALUOP=1:0);
  - the CTRL_BUBBLE constant (all zeros).
- The ID/EX and EX/MEM registers use the same package.
- There is one sub-module, sat_counter, with parameter W and ports clk_i, rst_i, clr_i, inc_i, cnt_o. It is instantiated twice.

## Test plan
- Reset: drive all inputs non-zero with rst_i=1 for 2 cycles -> every output is 0 and memread_o=0.
- Normal flow: valid_i=1, ctrl_i=8'hA4 (RegWrite, MemRead, RegDst), rs_data_i=32'h1234 -> the next cycle shows ctrl_o=8'hA4, memread_o=1, rs_data_o=32'h1234, valid_o=1.
- Load-use stall: load lw with rt=5, then stall_i=1 for one cycle -> that cycle gives valid_o=0, ctrl_o=0, data held, stall_cnt_o=1. The next cycle loads the dependent instruction.
- Priority:
  - flush_i=stall_i=hold_i=1 -> bubble, flush_cnt_o+1, stall_cnt_o unchanged.
  - hold_i=1 alone for 3 cycles -> outputs constant, counters unchanged.
- Saturation and clear, with CNT_W=4:
  - 20 consecutive stall cycles -> stall_cnt_o=15.
  - clr_cnt_i=1 together with stall_i=1 -> stall_cnt_o=0 on the next cycle.
- valid_i=0 with ctrl_i=8'hFF on a load cycle -> ctrl_o=0 and valid_o=0; counters unchanged.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the ID/EX and EX/MEM stage registers.
// Control word layout is {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[1:0]}.
package pipe_pkg;

    localparam int CTRL_W = 8;

    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_REGDST   = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/idex_pipe_reg_if.sv
// ID-side inputs and EX-side registered outputs of the ID/EX stage.
// The ID stage drives as master; the stage register consumes as slave.
interface idex_pipe_reg_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              valid_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic [DATA_W-1:0] pc4_i;
    logic [DATA_W-1:0] rs_data_i;
    logic [DATA_W-1:0] rt_data_i;
    logic [DATA_W-1:0] imm_i;
    logic [REG_AW-1:0] rs_addr_i;
    logic [REG_AW-1:0] rt_addr_i;
    logic [REG_AW-1:0] rd_addr_i;

    logic              valid_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [DATA_W-1:0] pc4_o;
    logic [DATA_W-1:0] rs_data_o;
    logic [DATA_W-1:0] rt_data_o;
    logic [DATA_W-1:0] imm_o;
    logic [REG_AW-1:0] rs_addr_o;
    logic [REG_AW-1:0] rt_addr_o;
    logic [REG_AW-1:0] rd_addr_o;
    logic              memread_o;

    modport master (
        output valid_i, ctrl_i, pc4_i, rs_data_i, rt_data_i, imm_i,
        output rs_addr_i, rt_addr_i, rd_addr_i,
        input  valid_o, ctrl_o, pc4_o, rs_data_o, rt_data_o, imm_o,
        input  rs_addr_o, rt_addr_o, rd_addr_o, memread_o
    );

    modport slave (
        input  valid_i, ctrl_i, pc4_i, rs_data_i, rt_data_i, imm_i,
        input  rs_addr_i, rt_addr_i, rd_addr_i,
        output valid_o, ctrl_o, pc4_o, rs_data_o, rt_data_o, imm_o,
        output rs_addr_o, rt_addr_o, rd_addr_o, memread_o
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous reset and clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != MAX)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with bubble insertion, hold, and
// saturating stall/flush event counters.
module idex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             hold_i,
    input  logic             clr_cnt_i,
    idex_pipe_reg_if.slave   bus,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic bubble;
    logic load;
    logic stall_ev;

    // Flush outranks hold; a stall only bubbles when the stage is not held.
    assign stall_ev = stall_i & ~flush_i & ~hold_i;
    assign bubble   = flush_i | stall_ev;
    assign load     = ~flush_i & ~hold_i & ~stall_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.valid_o   <= 1'b0;
            bus.ctrl_o    <= CTRL_BUBBLE;
            bus.pc4_o     <= '0;
            bus.rs_data_o <= '0;
            bus.rt_data_o <= '0;
            bus.imm_o     <= '0;
            bus.rs_addr_o <= '0;
            bus.rt_addr_o <= '0;
            bus.rd_addr_o <= '0;
        end else if (bubble) begin
            bus.valid_o <= 1'b0;
            bus.ctrl_o  <= CTRL_BUBBLE;
        end else if (load) begin
            bus.valid_o   <= bus.valid_i;
            bus.ctrl_o    <= bus.valid_i ? bus.ctrl_i : CTRL_BUBBLE;
            bus.pc4_o     <= bus.pc4_i;
            bus.rs_data_o <= bus.rs_data_i;
            bus.rt_data_o <= bus.rt_data_i;
            bus.imm_o     <= bus.imm_i;
            bus.rs_addr_o <= bus.rs_addr_i;
            bus.rt_addr_o <= bus.rt_addr_i;
            bus.rd_addr_o <= bus.rd_addr_i;
        end
    end

    assign bus.memread_o = bus.ctrl_o[CTRL_MEMREAD];

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_cnt_i),
        .inc_i (stall_ev),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_cnt_i),
        .inc_i (flush_i),
        .cnt_o (flush_cnt_o)
    );

endmodule
